// File: rtl/clock_set_controller.sv
// clock_set_controller: two-button editor for the clock time and alarm time.
// Optional feature macro: AUTOREPEAT_EN (auto-repeat of btn_inc while held).
//
// Ports:
//   clk, rst (async, active-low)       - clock and reset
//   btn_mode, btn_inc                  - debounced button levels, active-high
//   curr_minutes, curr_hours           - live time from the counters
//   hold_time                          - freezes the tick counter while editing time
//   time_load, load_minutes, load_hours - one-cycle load of the edited time
//   set_alarm, set_minutes, set_hours  - one-cycle commit of the stored alarm time
//   edit_target, edit_field, blink     - display hints for the digits under edit
module clock_set_controller #(
    parameter int unsigned TIMEOUT_TICKS = 500_000_000,
    parameter int unsigned BLINK_HALF    = 12_500_000,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_RATE   = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [6:0] curr_minutes,
    input  logic [5:0] curr_hours,
    output logic       hold_time,
    output logic       time_load,
    output logic [6:0] load_minutes,
    output logic [5:0] load_hours,
    output logic       set_alarm,
    output logic [6:0] set_minutes,
    output logic [5:0] set_hours,
    output logic       edit_target,
    output logic [1:0] edit_field,
    output logic       blink
);

    typedef enum logic [2:0] {IDLE, T_HOUR, T_MIN, A_HOUR, A_MIN} state_t;

`ifdef AUTOREPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    // Repeat logic is tied off and folds away as constant.
    localparam bit RPT_ON = 1'b0;
`endif

    state_t      state, state_n;
    logic        mode_q, inc_q;
    logic        mode_edge, inc_edge;
    logic [5:0]  edit_hours, edit_hours_n;
    logic [6:0]  edit_minutes, edit_minutes_n;
    logic [31:0] to_cnt, blink_cnt, rpt_cnt;
    logic        rpt_armed, rpt_first, rpt_fire;
    logic        bump, activity, tload_n, salarm_n;

    assign mode_edge = btn_mode & ~mode_q;
    assign inc_edge  = btn_inc & ~inc_q;

    always_comb begin
        rpt_fire = 1'b0;
        if (RPT_ON && rpt_armed && btn_inc && inc_q) begin
            if (rpt_first)
                rpt_fire = (rpt_cnt == REPEAT_DELAY);
            else
                rpt_fire = (rpt_cnt == REPEAT_RATE);
        end
    end

    always_comb begin
        state_n        = state;
        edit_hours_n   = edit_hours;
        edit_minutes_n = edit_minutes;
        tload_n        = 1'b0;
        salarm_n       = 1'b0;
        activity       = 1'b0;
        bump           = 1'b0;
        unique case (state)
            IDLE: if (mode_edge) begin
                state_n        = T_HOUR;
                edit_hours_n   = curr_hours;
                edit_minutes_n = curr_minutes;
            end
            T_HOUR: if (mode_edge) state_n = T_MIN;
            T_MIN: if (mode_edge) begin
                state_n        = A_HOUR;
                tload_n        = 1'b1;
                edit_hours_n   = set_hours;
                edit_minutes_n = set_minutes;
            end
            A_HOUR: if (mode_edge) state_n = A_MIN;
            A_MIN: if (mode_edge) begin
                state_n  = IDLE;
                salarm_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // Mode wins over a simultaneous increment; timeout only when quiet.
        if (state != IDLE) begin
            if (mode_edge) begin
                activity = 1'b1;
            end else if (inc_edge || rpt_fire) begin
                activity = 1'b1;
                bump     = 1'b1;
            end else if (to_cnt == TIMEOUT_TICKS - 1) begin
                state_n = IDLE;
            end
        end
        if (bump) begin
            if (state == T_HOUR || state == A_HOUR)
                edit_hours_n = (edit_hours >= 6'd23) ? 6'd0 : edit_hours + 6'd1;
            else
                edit_minutes_n = (edit_minutes >= 7'd59) ? 7'd0 : edit_minutes + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mode_q       <= 1'b0;
            inc_q        <= 1'b0;
            edit_hours   <= '0;
            edit_minutes <= '0;
            to_cnt       <= '0;
            blink_cnt    <= '0;
            rpt_cnt      <= '0;
            rpt_armed    <= 1'b0;
            rpt_first    <= 1'b0;
            hold_time    <= 1'b0;
            time_load    <= 1'b0;
            set_alarm    <= 1'b0;
            load_hours   <= '0;
            load_minutes <= '0;
            set_hours    <= '0;
            set_minutes  <= '0;
            edit_target  <= 1'b0;
            edit_field   <= 2'd0;
            blink        <= 1'b0;
        end else begin
            state        <= state_n;
            mode_q       <= btn_mode;
            inc_q        <= btn_inc;
            edit_hours   <= edit_hours_n;
            edit_minutes <= edit_minutes_n;
            to_cnt       <= (state_n == IDLE || activity) ? 32'd0 : to_cnt + 32'd1;

            if (state_n == IDLE || state_n != state) begin
                rpt_armed <= 1'b0;
            end else if (inc_edge) begin
                rpt_armed <= 1'b1;
                rpt_first <= 1'b1;
                rpt_cnt   <= 32'd1;
            end else if (!btn_inc) begin
                rpt_armed <= 1'b0;
            end else if (rpt_fire) begin
                rpt_first <= 1'b0;
                rpt_cnt   <= 32'd1;
            end else if (rpt_armed) begin
                rpt_cnt <= rpt_cnt + 32'd1;
            end

            if (state_n == IDLE) begin
                blink     <= 1'b0;
                blink_cnt <= '0;
            end else if (state_n != state) begin
                blink     <= 1'b1;
                blink_cnt <= '0;
            end else if (blink_cnt == BLINK_HALF - 1) begin
                blink     <= ~blink;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 32'd1;
            end

            // Hold stays up through the load cycle so the counter cannot tick over it.
            hold_time   <= (state_n == T_HOUR) || (state_n == T_MIN) || tload_n;
            time_load   <= tload_n;
            set_alarm   <= salarm_n;
            edit_target <= (state_n == A_HOUR) || (state_n == A_MIN);
            unique case (state_n)
                T_HOUR, A_HOUR: edit_field <= 2'd1;
                T_MIN, A_MIN:   edit_field <= 2'd2;
                default:        edit_field <= 2'd0;
            endcase
            if (tload_n) begin
                load_hours   <= edit_hours;
                load_minutes <= edit_minutes;
            end
            if (salarm_n) begin
                set_hours   <= edit_hours;
                set_minutes <= edit_minutes;
            end
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed scenarios with a pulse scoreboard.
// Expected load/commit pulses are queued by the stimulus and checked by a monitor.
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [6:0] curr_minutes = '0;
    logic [5:0] curr_hours = '0;
    logic       hold_time, time_load, set_alarm, edit_target, blink;
    logic [6:0] load_minutes, set_minutes;
    logic [5:0] load_hours, set_hours;
    logic [1:0] edit_field;

    typedef struct {
        bit alarm;
        int hours;
        int minutes;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_rpt_min;

    clock_set_controller #(
        .TIMEOUT_TICKS(100),
        .BLINK_HALF(4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .curr_minutes(curr_minutes),
        .curr_hours(curr_hours),
        .hold_time(hold_time),
        .time_load(time_load),
        .load_minutes(load_minutes),
        .load_hours(load_hours),
        .set_alarm(set_alarm),
        .set_minutes(set_minutes),
        .set_hours(set_hours),
        .edit_target(edit_target),
        .edit_field(edit_field),
        .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit m, input bit i);
        btn_mode = m;
        btn_inc  = i;
        step(1);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(1);
    endtask

    task automatic incs(input int n);
        repeat (n) press(1'b0, 1'b1);
    endtask

    task automatic expect_pulse(input bit alarm, input int h, input int m);
        exp_t e;
        e.alarm   = alarm;
        e.hours   = h;
        e.minutes = m;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] all_outs();
        return {31'd0, hold_time, time_load, load_minutes, load_hours,
                set_alarm, set_minutes, set_hours, edit_target, edit_field, blink};
    endfunction

    // Monitor: every load/commit pulse must match the oldest queued expectation.
    initial begin
        bit   prev_pulse = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (time_load || set_alarm) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL pulse_unexpected: tl=%0b sa=%0b, want none", time_load, set_alarm);
                end else begin
                    e = sb.pop_front();
                    if ((time_load && set_alarm) || prev_pulse ||
                        (set_alarm != e.alarm) ||
                        (time_load && !hold_time) ||
                        (e.alarm ? (int'(set_hours) != e.hours || int'(set_minutes) != e.minutes)
                                 : (int'(load_hours) != e.hours || int'(load_minutes) != e.minutes))) begin
                        miscompares++;
                        $display("FAIL pulse: tl=%0b sa=%0b hold=%0b load=%0d:%0d set=%0d:%0d, want alarm=%0b %0d:%0d",
                                 time_load, set_alarm, hold_time, load_hours, load_minutes,
                                 set_hours, set_minutes, e.alarm, e.hours, e.minutes);
                    end
                end
            end
            prev_pulse = time_load | set_alarm;
        end
    end

    initial begin
`ifdef AUTOREPEAT_EN
        exp_rpt_min = 5;
`else
        exp_rpt_min = 1;
`endif
        step(3);
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b1;
        step(2);
        check("idle_outputs", all_outs(), 64'd0);

        // Full time set, then alarm commit.
        curr_hours = 6'd13;
        curr_minutes = 7'd45;
        press(1'b1, 1'b0);
        check("t_hour_state", {hold_time, edit_target, edit_field, blink}, {1'b1, 1'b0, 2'd1, 1'b1});
        incs(3);
        press(1'b1, 1'b0);
        check("t_min_state", {hold_time, edit_target, edit_field}, {1'b1, 1'b0, 2'd2});
        incs(20);
        check("hold_before_load", hold_time, 1'b1);
        expect_pulse(1'b0, 16, 5);
        press(1'b1, 1'b0);
        check("a_hour_state", {hold_time, edit_target, edit_field}, {1'b0, 1'b1, 2'd1});
        check("load_value", {load_hours, load_minutes}, {6'd16, 7'd5});
        incs(7);
        press(1'b1, 1'b0);
        check("a_min_state", {edit_target, edit_field}, {1'b1, 2'd2});
        incs(30);
        expect_pulse(1'b1, 7, 30);
        press(1'b1, 1'b0);
        check("alarm_commit", {set_hours, set_minutes}, {6'd7, 7'd30});
        check("idle_after_commit", {hold_time, edit_target, edit_field, blink}, 5'd0);

        // Wraps: hours 23 -> 0, alarm minutes 59 -> 0.
        curr_hours = 6'd23;
        curr_minutes = 7'd59;
        press(1'b1, 1'b0);
        incs(1);
        press(1'b1, 1'b0);
        expect_pulse(1'b0, 0, 59);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        incs(30);
        expect_pulse(1'b1, 7, 0);
        press(1'b1, 1'b0);
        check("wrap_alarm", {set_hours, set_minutes}, {6'd7, 7'd0});

        // Timeout in T_MIN: 100 quiet cycles abandon the edit, no pulse.
        curr_hours = 6'd10;
        curr_minutes = 7'd20;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        step(3);
        check("blink_toggle", blink, 1'b0);
        step(4);
        check("blink_toggle_back", blink, 1'b1);
        step(91);
        check("before_timeout", {hold_time, edit_field}, {1'b1, 2'd2});
        step(1);
        check("after_timeout", {hold_time, edit_field, blink}, 4'd0);

        // Simultaneous mode+inc in T_HOUR: mode wins.
        curr_hours = 6'd5;
        curr_minutes = 7'd10;
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        check("simul_to_t_min", edit_field, 2'd2);
        expect_pulse(1'b0, 5, 10);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        incs(3);
        check("pre_reset_a_min", {edit_target, edit_field}, {1'b1, 2'd2});
        rst = 1'b0;
        #2;
        check("reset_mid_edit", all_outs(), 64'd0);
        step(2);
        rst = 1'b1;
        step(2);
        check("after_reset_idle", all_outs(), 64'd0);

        // Held increment in T_MIN from 0.
        curr_hours = 6'd2;
        curr_minutes = 7'd0;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        btn_inc = 1'b1;
        step(20);
        btn_inc = 1'b0;
        step(1);
        expect_pulse(1'b0, 2, exp_rpt_min);
        press(1'b1, 1'b0);
        check("hold_inc_minutes", load_minutes, 7'(exp_rpt_min));

        step(3);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
